// File: rtl/tbird_mode_ctrl_if.sv
// Driver-request / sequencer-control bundle for the T-bird tail-light front end.
// The master drives the raw driver inputs; the slave (the mode controller) drives the mode outputs.
interface tbird_mode_ctrl_if;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic       brake;
  logic [2:0] switch;
  logic       step;
  logic [2:0] phase;
  logic       busy;

  modport master (
    output left_req, right_req, hazard_req, brake,
    input  switch, step, phase, busy
  );

  modport slave (
    input  left_req, right_req, hazard_req, brake,
    output switch, step, phase, busy
  );
endinterface

// File: rtl/tbird_mode_ctrl.sv
// T-bird tail-light front end: debounces driver inputs, arbitrates them into a direction FSM,
// and emits the sequencer mode code plus a prescaled step pulse aligned to sequence boundaries.
module tbird_mode_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 10,
  parameter int STEP_COUNT = 5
) (
  input  logic             clock,
  input  logic             reset,
  tbird_mode_ctrl_if.slave bus
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TCW = $clog2(TICK_DIV);
  localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEB_CYCLES - 1);
  localparam logic [DCW-1:0] DEB_ONE    = DCW'(1);
  localparam logic [DCW-1:0] DEB_ZERO   = DCW'(0);
  localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
  localparam logic [TCW-1:0] TICK_ONE   = TCW'(1);
  localparam logic [TCW-1:0] TICK_ZERO  = TCW'(0);
  localparam logic [2:0]     PHASE_LAST = 3'(STEP_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RIGHT  = 2'b01,
    LEFT   = 2'b10,
    HAZARD = 2'b11
  } state_t;

  // Request codes share the state encoding so a request maps directly onto its target state.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_R    = 2'b01,
    REQ_L    = 2'b10,
    REQ_HAZ  = 2'b11
  } req_t;

  // Bit order of the filter bank: 0 left, 1 right, 2 hazard, 3 brake.
  logic [3:0]     raw_s;
  logic [3:0]     filt_r;
  logic [DCW-1:0] deb_cnt_r [4];

  state_t         state_r;
  state_t         state_nxt_s;
  req_t           req_s;
  logic           boundary_s;
  logic           restart_s;
  logic [TCW-1:0] tick_r;
  logic           hold_r;
  logic           step_r;
  logic [2:0]     phase_r;
  logic [2:0]     switch_r;
  logic           busy_r;

  assign raw_s = {bus.brake, bus.hazard_req, bus.right_req, bus.left_req};

  // Per-input debounce: filtered value follows raw after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw_s[i] != filt_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            filt_r[i]    <= raw_s[i];
            deb_cnt_r[i] <= DEB_ZERO;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
          end
        end else begin
          deb_cnt_r[i] <= DEB_ZERO;
        end
      end
    end
  end

  // Priority decode of filtered levers; both levers together count as hazard.
  always_comb begin
    req_s = REQ_NONE;
    if (filt_r[2] | (filt_r[0] & filt_r[1])) begin
      req_s = REQ_HAZ;
    end else if (filt_r[0]) begin
      req_s = REQ_L;
    end else if (filt_r[1]) begin
      req_s = REQ_R;
    end else begin
      req_s = REQ_NONE;
    end
  end

  assign boundary_s = step_r & (phase_r == PHASE_LAST);

  // Next direction state: hazard pre-empts at once, all other changes wait for a boundary.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        state_nxt_s = state_t'(req_s);
      end
      LEFT, RIGHT: begin
        if (req_s == REQ_HAZ) begin
          state_nxt_s = HAZARD;
        end else if (boundary_s) begin
          state_nxt_s = state_t'(req_s);
        end else begin
          state_nxt_s = state_r;
        end
      end
      HAZARD: begin
        if (boundary_s) begin
          state_nxt_s = state_t'(req_s);
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign restart_s = (state_nxt_s != state_r);

  // FSM, prescaler, phase and mode outputs, all updated together.
  // On a restart the prescaler is parked one extra clock so the first step lands TICK_DIV+1 after entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      switch_r <= 3'b000;
      busy_r   <= 1'b0;
      tick_r   <= TICK_ZERO;
      hold_r   <= 1'b0;
      step_r   <= 1'b0;
      phase_r  <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      switch_r <= {filt_r[3], state_nxt_s};
      busy_r   <= (state_nxt_s != IDLE);
      if ((state_nxt_s == IDLE) || restart_s) begin
        tick_r  <= TICK_ZERO;
        hold_r  <= (state_nxt_s != IDLE);
        step_r  <= 1'b0;
        phase_r <= 3'd0;
      end else if (hold_r) begin
        tick_r <= TICK_ZERO;
        hold_r <= 1'b0;
        step_r <= 1'b0;
      end else begin
        if (tick_r == TICK_LAST) begin
          tick_r <= TICK_ZERO;
          step_r <= 1'b1;
        end else begin
          tick_r <= tick_r + TICK_ONE;
          step_r <= 1'b0;
        end
        if (step_r) begin
          phase_r <= (phase_r == PHASE_LAST) ? 3'd0 : (phase_r + 3'd1);
        end
      end
    end
  end

  assign bus.switch = switch_r;
  assign bus.step   = step_r;
  assign bus.phase  = phase_r;
  assign bus.busy   = busy_r;

endmodule

// File: doc/tbird_mode_ctrl.md
Name: tbird_mode_ctrl

Overview:
- Front-end controller for the T-bird tail-light sequencer.
- Debounces the driver inputs (left lever, right lever, hazard, brake) and arbitrates them into a direction state machine.
- Generates the sequencer's 3-bit mode code `switch` and a prescaled `step` enable.
- Mode changes land only on sequence boundaries, so the sequencer never restarts mid-pattern except for hazard pre-emption, brake, or reset.

Parameters:
- DEB_CYCLES, 4, consecutive clocks a raw input must differ from its filtered value before the filtered value updates.
- TICK_DIV, 10, clocks per `step` pulse (≥2).
- STEP_COUNT, 5, steps per light sequence: 4 lamp stages plus 1 blank.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- left_req  input  1  raw left-turn lever.
- right_req  input  1  raw right-turn lever.
- hazard_req  input  1  raw hazard switch.
- brake  input  1  raw brake pedal.
- switch  output  3  mode code to the sequencer: {brake_f, dir[1:0]}.
- step  output  1  one-clock advance pulse to the sequencer.
- phase  output  3  current step index within the sequence, 0..STEP_COUNT-1.
- busy  output  1  1 when the FSM is not IDLE.

Behaviour:
- Reset (clock edge with reset=1):
  - All filtered inputs, counters, phase and step = 0.
  - FSM = IDLE, switch = 000, busy = 0.
  - Reset overrides every other event and applies mid-operation.
- Debounce (one filter per input, own counter):
  - If raw != filtered, the counter increments; otherwise it clears.
  - When the counter reaches DEB_CYCLES-1 and raw still differs, filtered <= raw on that edge and the counter clears.
  - Net effect: filtered follows raw on the DEB_CYCLES-th consecutive differing sample.
  - Shorter pulses are ignored.
- Request decode (combinational, from filtered values):
  - hazard_f | (left_f & right_f) -> REQ_HAZ
  - else left_f -> REQ_L
  - else right_f -> REQ_R
  - else REQ_NONE.
- FSM states and dir encoding: IDLE (00), RIGHT (01), LEFT (10), HAZARD (11).
- IDLE transitions:
  - Any request other than REQ_NONE: go to the requested state on the next edge.
  - On entry: phase = 0, prescaler cleared.
- Active-state (RIGHT, LEFT, HAZARD) transitions:
  - REQ_HAZ while in LEFT/RIGHT: go to HAZARD on the next edge (pre-emption); phase = 0, prescaler cleared.
  - Any other request differing from the current state, including REQ_NONE: taken only on the edge where step=1 and phase = STEP_COUNT-1 (the boundary).
  - On that boundary: new state, phase = 0, prescaler cleared.
  - Request returning to match the current state before the boundary: no change, nothing pending is remembered.
- Prescaler (runs only when not IDLE):
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - step is registered; it is 1 on the clock after the counter equals TICK_DIV-1, for exactly one clock.
  - In IDLE, step = 0 and the counter is held at 0.
  - The first step after entering an active state arrives TICK_DIV+1 clocks after entry.
- Phase:
  - Increments on each step; wraps from STEP_COUNT-1 to 0.
  - Held at 0 in IDLE.
  - Width 3 bits; STEP_COUNT ≤ 8.
- switch (registered):
  - switch[1:0] = encoding of the FSM state after the edge.
  - switch[2] = brake_f, applied one clock after brake_f changes, independent of boundaries.
  - Brake changes never alter phase, FSM state or the prescaler.
- Simultaneous events:
  - Boundary and hazard request on the same edge: HAZARD.
  - Brake change and direction change on the same edge: both reflected in that same switch update.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: hold reset 3 clocks with all inputs 1, then release with inputs 0 -> switch=000, step=0, phase=0, busy=0 throughout.
- Left sequence: left_req=1 from cycle 0 -> left_f=1 at edge 4, switch=010 and busy=1 at edge 5; step pulses every 10 clocks; phase 0,1,2,3,4,0.
- Glitch reject: left_req=1 for 3 clocks then 0 -> switch stays 000, busy stays 0.
- Deferred change: in LEFT at phase 2, drop left_req and raise right_req -> switch stays 010 until the step where phase=4, then 001 with phase=0.
- Hazard pre-empt: in RIGHT at phase 1, raise hazard_req -> switch=011 one edge after hazard_f rises, phase=0, next step 11 clocks later; same result with left_req=right_req=1.
- Brake overlay and reset mid-run: in RIGHT at phase 3, brake=1 -> switch=101 with phase unaffected; brake=1 in IDLE -> switch=100; assert reset -> switch=000, phase=0 on the next edge.
